// File: rtl/serial_wide_adder_pkg.sv
// Shared definitions for the byte-serial wide adder: byte width, FSM states
// and the byte-index width helper.
package serial_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-byte build would still need a 1-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/serial_wide_adder_if.sv
// Operand request and result handshakes of the byte-serial wide adder.
// Port ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_wide_adder_if #(
    parameter int NBYTES = 4
);
    localparam int W = serial_add_pkg::BYTE_W * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_wide_adder_cla.sv
// Combinational 8-bit adder built from a per-bit propagate/generate carry chain.
module cla_add8 (
    input  logic [7:0] a8,
    input  logic [7:0] b8,
    input  logic       ci,
    output logic [7:0] s8,
    output logic       co
);

    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;

    assign p = a8 ^ b8;
    assign g = a8 & b8;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s8 = p ^ c[7:0];
    assign co = c[8];

endmodule

// File: rtl/serial_wide_adder.sv
// Byte-serial wide adder: one 8-bit CLA step per cycle, LSB byte first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_wide_adder
    import serial_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_wide_adder_if.slave bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);

    state_t             state, state_nxt;
    logic               in_ready, out_valid;
    logic               accept, last_step;

    logic [W-1:0]       a_sh, b_sh, sum_q;
    logic               carry_q, cout_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BYTE_W-1:0]  s8;
    logic               co8;

    assign accept    = bus.in_valid && in_ready;
    assign last_step = (state == RUN) && (idx_q == IDX_W'(NBYTES - 1));

    // Operands shift down one byte per step, so the current byte is always at [7:0].
    cla_add8 u_cla (
        .a8 (a_sh[BYTE_W-1:0]),
        .b8 (b_sh[BYTE_W-1:0]),
        .ci (carry_q),
        .s8 (s8),
        .co (co8)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE: if (bus.in_valid)  state_nxt = RUN;
            RUN:  if (last_step)     state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            sum_q   <= '0;
            carry_q <= bus.cin;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (state == RUN) begin
            a_sh                         <= a_sh >> BYTE_W;
            b_sh                         <= b_sh >> BYTE_W;
            sum_q[BYTE_W*idx_q +: BYTE_W] <= s8;
            carry_q                      <= co8;
            idx_q                        <= idx_q + IDX_W'(1);
            if (last_step) begin
                cout_q <= co8;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the last step the low byte of each shift register is the top operand byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_step) begin
            ovf_q <= (a_sh[BYTE_W-1] == b_sh[BYTE_W-1]) && (s8[BYTE_W-1] != a_sh[BYTE_W-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_wide_adder.sv
// Directed bench for serial_wide_adder (NBYTES=4); covers ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_wide_adder;

    localparam int NBYTES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_wide_adder_if #(.NBYTES(NBYTES)) bus ();

    serial_wide_adder #(.NBYTES(NBYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [8];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic get_ovf();
`ifdef SERIAL_ADD_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Waits for in_ready, issues one request, scrambles operands after accept,
    // then waits (bounded) for out_valid. lat = -1 on timeout.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                          output logic [31:0] rs, output logic rc, output logic ro,
                          output int lat);
        int n;
        lat = -1;
        n   = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tc;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.cin      = ~tc;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        rs = bus.sum;
        rc = bus.cout;
        ro = get_ovf();
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs, hold_s;
        logic        rc, ro, hold_c;
        int          lat;
        int          acc [3];
        logic [31:0] bb_a [3], bb_b [3], bb_s [3];
        logic        bb_ci [3], bb_co [3];
        int          k, r, cyc;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
        vecs[5] = '{32'hDEADBEEF, 32'h21524110, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0, 1'b0};
        vecs[7] = '{32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(get_ovf()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, ro, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].co));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].ov));
`endif
            release_out();
        end

        // Backpressure: result must hold and a second request must be ignored.
        run_op(32'h12345678, 32'h11111111, 1'b1, rs, rc, ro, lat);
        hold_s = rs;
        hold_c = rc;
        check("bp_sum_first", 64'(hold_s), 64'h2345678A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = 32'h0000FFFF;
            bus.b        = 32'h00000001;
            @(posedge clk);
            #1;
            check("bp_sum_hold", 64'(bus.sum), 64'(hold_s));
            check("bp_cout_hold", 64'(bus.cout), 64'(hold_c));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        release_out();
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_accept", 64'(bus.in_ready), 64'd1);

        // Reset in the middle of a RUN.
        @(negedge clk);
        bus.a        = 32'hFFFFFFFF;
        bus.b        = 32'hFFFFFFFF;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_sum", 64'(bus.sum), 64'd0);
        check("mid_rst_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h00000001, 32'h00000001, 1'b0, rs, rc, ro, lat);
        check("post_rst_latency", 64'(lat), 64'd4);
        check("post_rst_sum", 64'(rs), 64'h00000002);
        check("post_rst_cout", 64'(rc), 64'd0);
        release_out();

        // Back-to-back with in_valid and out_ready held high.
        bb_a[0] = 32'h00000001; bb_b[0] = 32'h00000002; bb_ci[0] = 1'b0;
        bb_s[0] = 32'h00000003; bb_co[0] = 1'b0;
        bb_a[1] = 32'hFFFFFFFF; bb_b[1] = 32'hFFFFFFFF; bb_ci[1] = 1'b1;
        bb_s[1] = 32'hFFFFFFFF; bb_co[1] = 1'b1;
        bb_a[2] = 32'h0F0F0F0F; bb_b[2] = 32'hF0F0F0F0; bb_ci[2] = 1'b0;
        bb_s[2] = 32'hFFFFFFFF; bb_co[2] = 1'b0;
        acc = '{-1, -1, -1};
        k = 0;
        r = 0;
        bus.out_ready = 1'b1;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (r == 3) break;
            if (bus.in_ready) begin
                if (k < 3) begin
                    bus.a        = bb_a[k];
                    bus.b        = bb_b[k];
                    bus.cin      = bb_ci[k];
                    bus.in_valid = 1'b1;
                    acc[k]       = cyc;
                    k++;
                end
            end else if (k == 3) begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                check($sformatf("b2b%0d_sum", r), 64'(bus.sum), 64'(bb_s[r]));
                check($sformatf("b2b%0d_cout", r), 64'(bus.cout), 64'(bb_co[r]));
                r++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_results", 64'(r), 64'd3);
        check("b2b_gap01", 64'(acc[1] - acc[0]), 64'd6);
        check("b2b_gap12", 64'(acc[2] - acc[1]), 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_wide_adder.md
# serial_wide_adder

- Byte-serial wide adder: accepts two NBYTES-byte operands plus carry-in over a valid/ready handshake.
- Adds them least-significant byte first through one 8-bit carry-lookahead stage, one byte per cycle, with the carry held in a register between bytes.
- Presents the full-width sum and carry-out over a second valid/ready handshake.
- Sits directly upstream of the 8-bit CLA datapath: it sequences operand bytes into that stage and consumes its sum/carry outputs.

## Interface
Parameters:
- NBYTES, 4, operand width in bytes (legal range 2..16); operand width W = 8*NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in to byte 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result, (a+b+cin) mod 2^W.
- cout  output  1  carry out of bit W-1.
- ovf  output  1  signed overflow flag; present only when SERIAL_ADD_OVF_EN is defined.

## Operation
- FSM states and transitions:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after NBYTES byte steps.
  - DONE → IDLE on out_valid && out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded directly from the state register.
- On accept:
  - a and b are latched into operand shift registers.
  - The carry register is loaded with cin.
  - The byte index is cleared to 0.
  - The sum register is cleared.
- Each RUN cycle:
  - The CLA adds a[idx], b[idx] and the carry register.
  - The result byte is written to sum[8*idx +: 8].
  - The carry register takes the CLA carry-out.
  - idx increments.
  - On the cycle where idx = NBYTES-1, the final carry is written to cout and the state goes to DONE.
- In DONE, sum, cout and ovf are held stable until the output handshake completes.
- Input is ignored whenever in_ready=0. Operand inputs are sampled only on the accept edge, so a and b may change freely afterwards.
- Arithmetic: unsigned modular addition at width W. Carry-out is exact at 9 bits per byte step. No saturation.
- rst asserted in any state, including mid-RUN, forces the reset values below. A partially computed result is discarded and never presented.

## Timing
Reset values:
- state=IDLE, in_ready=1, out_valid=0.
- sum=0, cout=0, ovf=0.
- Carry register=0, idx=0.

Latency and throughput:
- Accept at edge E0; byte steps on edges E1..E_NBYTES; out_valid is high from E_NBYTES, i.e. NBYTES cycles after accept.
- The earliest return to IDLE is the edge on which out_ready is sampled high with out_valid. The next accept is one edge later.
- Sustained throughput with in_valid and out_ready held high: one operation per NBYTES+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- The critical path is one 8-bit CLA plus the byte-select mux.

## Configuration
- Macro: SERIAL_ADD_OVF_EN.
- With the macro defined:
  - Port ovf exists.
  - ovf is set in the final RUN step to (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
  - ovf is held through DONE and cleared on accept and on reset.
- Without the macro: no ovf port and no associated logic. All other behaviour is identical.

## Structure
- Package serial_add_pkg holds:
  - BYTE_W = 8.
  - The FSM state enum (IDLE, RUN, DONE).
  - A function giving the index width, $clog2(NBYTES).
- Sub-module cla_add8 is combinational: inputs a8, b8, ci; outputs s8, co. It is built as a per-bit propagate/generate carry chain and instantiated once.

## Test plan
Directed scenarios (NBYTES=4 unless stated):
- a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1; out_valid rises exactly 4 cycles after accept.
- a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum and cout stable, in_ready=0, a second in_valid pulse is not accepted; raise out_ready → IDLE on the next edge.
- Reset mid-operation: assert rst after byte 2 → out_valid=0, in_ready=1, sum=0 immediately; the next operation 0x00000001+0x00000001 gives 0x00000002.
- With SERIAL_ADD_OVF_EN: a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, ovf=1; a=0xFFFFFFFF, b=0x00000001 → ovf=0, cout=1.
- Back-to-back: in_valid and out_ready held high for 3 operations → accepts spaced exactly 6 cycles apart, all three results correct.
